// File: rtl/barrett_reduce_pipe_if.sv
// ============================================================================
// Module      : barrett_reduce_pipe_if
// Description : Valid/ready input and output channels of barrett_reduce_pipe.
//               Optional macro BARRETT_TAG_EN adds the din_tag/dout_tag sideband.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface barrett_reduce_pipe_if #(
  parameter int K    = 8,
  parameter int IN_W = 2*K-1
`ifdef BARRETT_TAG_EN
  ,
  parameter int TAG_W = 4
`endif
);
  logic            din_valid;
  logic            din_ready;
  logic [IN_W-1:0] din_a;
  logic            dout_valid;
  logic            dout_ready;
  logic [K-1:0]    dout_r;
`ifdef BARRETT_TAG_EN
  logic [TAG_W-1:0] din_tag;
  logic [TAG_W-1:0] dout_tag;

  modport master (
    output din_valid, din_a, din_tag, dout_ready,
    input  din_ready, dout_valid, dout_r, dout_tag
  );
  modport slave (
    input  din_valid, din_a, din_tag, dout_ready,
    output din_ready, dout_valid, dout_r, dout_tag
  );
`else
  modport master (
    output din_valid, din_a, dout_ready,
    input  din_ready, dout_valid, dout_r
  );
  modport slave (
    input  din_valid, din_a, dout_ready,
    output din_ready, dout_valid, dout_r
  );
`endif
endinterface

`default_nettype wire

// File: rtl/barrett_reduce_pipe.sv
// ============================================================================
// Module      : barrett_reduce_pipe
// Description : Three-stage pipelined Barrett reducer, dout_r = din_a mod Q.
//               Optional macro BARRETT_TAG_EN carries a tag alongside each word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module barrett_reduce_pipe #(
  parameter int Q     = 227,
  parameter int K     = 8,
  parameter int IN_W  = 2*K-1,
  parameter int NCORR = 3
`ifdef BARRETT_TAG_EN
  ,
  parameter int TAG_W = 4
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  barrett_reduce_pipe_if.slave bus
);

  localparam int              c_rw     = IN_W + 1;
  localparam logic [c_rw-1:0] MU       = c_rw'((64'd1 << (2*K)) / Q);
  localparam logic [c_rw-1:0] c_q_ext  = c_rw'(Q);

  logic              w_en;
  logic              r_v1, r_v2, r_v3;
  logic [IN_W-1:0]   r_a1, r_a2;
  logic [c_rw-1:0]   r_prod1, r_rem2;
  logic [K-1:0]      r_rem3;
  logic [c_rw-1:0]   w_q1_ext, w_prod, w_t_ext, w_rem, w_res;
  logic [c_rw-1:0]   w_corr [NCORR+1];

  // Whole pipeline advances together; a stalled output freezes every stage.
  assign w_en          = ~r_v3 | bus.dout_ready;
  assign bus.din_ready = w_en;

  assign w_q1_ext = c_rw'(bus.din_a >> K);
  assign w_prod   = w_q1_ext * MU;
  assign w_t_ext  = r_prod1 >> K;
  assign w_rem    = c_rw'(r_a1) - w_t_ext * c_q_ext;

  assign w_corr[0] = r_rem2;
  generate
    for (genvar i = 0; i < NCORR; i++) begin : g_corr
      assign w_corr[i+1] = (w_corr[i] >= c_q_ext) ? (w_corr[i] - c_q_ext) : w_corr[i];
    end
  endgenerate

  // Operands already below Q are their own remainder.
  assign w_res = (c_rw'(r_a2) < c_q_ext) ? c_rw'(r_a2) : w_corr[NCORR];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_a1    <= '0;
      r_a2    <= '0;
      r_prod1 <= '0;
      r_rem2  <= '0;
      r_rem3  <= '0;
    end else if (w_en) begin
      r_v1    <= bus.din_valid;
      r_v2    <= r_v1;
      r_v3    <= r_v2;
      r_a1    <= bus.din_a;
      r_prod1 <= w_prod;
      r_a2    <= r_a1;
      r_rem2  <= w_rem;
      r_rem3  <= K'(w_res);
    end
  end

  assign bus.dout_valid = r_v3;
  assign bus.dout_r     = r_rem3;

`ifdef BARRETT_TAG_EN
  logic [TAG_W-1:0] r_tag1, r_tag2, r_tag3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag1 <= '0;
      r_tag2 <= '0;
      r_tag3 <= '0;
    end else if (w_en) begin
      r_tag1 <= bus.din_tag;
      r_tag2 <= r_tag1;
      r_tag3 <= r_tag2;
    end
  end

  assign bus.dout_tag = r_tag3;
`endif

endmodule

`default_nettype wire

// File: doc/barrett_reduce_pipe.md
Name: barrett_reduce_pipe

Overview:
- Parametrised, pipelined Barrett modular reducer: dout_r = din_a mod Q for any din_a < 2^(2K-1).
- Generalises the fixed-modulus combinational reducer to any K-bit modulus Q.
- Three-stage pipeline, fully exact correction, valid/ready handshake on both sides.
- Sits between the field multiplier and downstream Galois datapath consumers.

Parameters:
- Q, 227, modulus; must satisfy 2^(K-1) < Q < 2^K.
- K, 8, modulus bit width.
- IN_W, 2*K-1, input width.
- MU, floor(2^(2K)/Q), Barrett constant; localparam derived from Q and K, not overridable.
- NCORR, 3, number of conditional-subtract correction steps in the final stage.
- TAG_W, 4, sideband tag width; used only when BARRETT_TAG_EN is defined.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- din_valid  in  1  input word valid.
- din_ready  out  1  block can accept input this cycle.
- din_a  in  IN_W  operand to reduce.
- dout_valid  out  1  result valid.
- dout_ready  in  1  consumer accepts result.
- dout_r  out  K  din_a mod Q.
- din_tag / dout_tag  in / out  TAG_W  sideband; present only with BARRETT_TAG_EN.

Behaviour:
- Arithmetic per accepted word:
  - q1 = a >> K
  - t = (q1*MU) >> K
  - r = a - t*Q, computed at width IN_W+1
  - then NCORR steps of "if r >= Q then r = r - Q".
- Error bound: the estimate t undershoots floor(a/Q) by at most 3, so NCORR=3 gives an exact remainder for every legal input. No result may ever be >= Q.
- Stage S1 registers a and the product q1*MU.
- Stage S2 registers a and r.
- Stage S3 registers the corrected remainder.
- Each stage carries its own valid bit: v1, v2, v3.
- Latency: 3 cycles from accept (din_valid & din_ready) to dout_valid, provided there is no backpressure.
- Pipeline advance enable: en = ~v3 | dout_ready.
  - din_ready = en, combinational; no combinational path from din_valid to din_ready.
  - When en=1, all stages shift: v1 <= din_valid, v2 <= v1, v3 <= v2, and data moves with them.
  - When en=0, all stage registers and valid bits hold.
- Output: dout_valid = v3; dout_r = S3 data.
  - dout_r holds stable while dout_valid & ~dout_ready.
- Throughput: one result per cycle with dout_ready held high.
- Bubbles: bubbles propagate as invalid stages and are not compressed. Full capacity is 3 words.
- Simultaneous accept and drain: in the same cycle, this is legal and occupancy is unchanged.
- Reset: rst_n low, asynchronously at any time including mid-stream, clears v1, v2, v3 and all data registers to 0.
  - dout_valid=0, dout_r=0.
  - din_ready=1 is combinationally derived, so it is 1 while in reset; inputs presented during reset are discarded.
  - In-flight words are dropped.
- Data registers of invalid stages are don't-care for verification, but must still reset to 0.

Optional Feature:
- Macro: BARRETT_TAG_EN.
- Defined: din_tag/dout_tag ports exist.
  - The tag travels through three registers in lockstep with the data and obeys the same enable.
  - dout_tag equals the tag accepted with the same word. Tags reset to 0.
- Undefined: no tag ports and no tag registers; the datapath is otherwise identical.

Test Plan:
- Corner values, Q=227, K=8, dout_ready=1: din_a = 0, 226, 227, 1000, 32767 -> dout_r = 0, 226, 0, 92, 79, each 3 cycles after accept, back-to-back in order.
- Exhaustive check, Q=227: stream din_a = 0..32767 with random din_valid gaps -> every dout_r == din_a % 227, and every dout_r < 227.
- Backpressure: hold dout_ready=0, offer words 5, 500, 5000, 20000 -> first three accepted, din_ready=0 on the fourth. Raise dout_ready -> outputs 5, 46, 6, 24 in order; the fourth is accepted on the first enabled cycle.
- Reset mid-stream: assert rst_n=0 with 2 words in flight -> dout_valid=0 and dout_r=0 immediately. After release, no stale output appears; a new din_a=454 yields 0.
- Second parameter set, Q=3329, K=12 (MU=5039): din_a = 8388607, 3329, 3328 -> dout_r = 2856, 0, 3328.
- Tag path, with BARRETT_TAG_EN: tags 0x3, 0xA, 0xF with random dout_ready stalls -> dout_tag matches its word in every cycle where dout_valid=1.
